// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: digit/control inputs and display outputs of the
// four-digit seven-segment scanner.
//   digits_in [15:0] four BCD digits, [3:0] = rightmost digit
//   load             1-cycle strobe, capture digits_in
//   lzb              leading-zero blanking enable (live)
//   segments  [6:0]  active-high segments, [0]=a .. [6]=g
//   digit_en  [3:0]  one-hot active-high digit select
//   frame_done       1-cycle pulse at each frame boundary
// master = digit source / display driver side, slave = scanner.
interface seg7_scan_mux_if;
  logic [15:0] digits_in;
  logic        load;
  logic        lzb;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  modport master (output digits_in, load, lzb,
                  input  segments, digit_en, frame_done);
  modport slave  (input  digits_in, load, lzb,
                  output segments, digit_en, frame_done);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_digit_dec: BCD to seven-segment pattern; codes 10-15 show a dash.
//   bcd [3:0] in, seg [6:0] out ([0]=a .. [6]=g, active high)
//
// seg7_scan_mux: four-digit time-multiplexed seven-segment scanner.
// Each slot is BLANK dark cycles followed by DWELL lit cycles; slots scan
// digit 0..3. Loaded digits sit in a pending register and are copied into
// the displayed shadow only at a frame boundary, so a frame never mixes
// old and new digits.
//   clk, reset_n   clock, asynchronous active-low reset
//   bus (slave)    digits_in/load/lzb in, segments/digit_en/frame_done out
module seg7_digit_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
  end
endmodule

module seg7_scan_mux #(
  parameter int DWELL = 250,
  parameter int BLANK = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  seg7_scan_mux_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int MAXC       = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW         = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state, state_d;
  logic [1:0]      idx, idx_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      en_q, en_d;
  logic            fd_q, fd_d;

  logic [15:0]     shadow, pending;
  logic            pending_valid;
  logic            boundary;

  logic [NUM_DIGITS-1:0][6:0] dec_pat;
  logic [NUM_DIGITS-1:0]      sup;

  // One decoder per digit slot, all fed from the frame-stable shadow.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    seg7_digit_dec u_dec (.bcd(shadow[4*k +: 4]), .seg(dec_pat[k]));
    // Digit k is a leading zero when it and every digit left of it is 0;
    // the rightmost digit always shows.
    if (k == 0) begin : g_d0
      assign sup[k] = 1'b0;
    end else begin : g_dn
      assign sup[k] = bus.lzb & ~|shadow[15:4*k];
    end
  end

  assign boundary = (state == ST_SHOW) && (cnt == DWELL_LAST) && (idx == 2'd3);

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    seg_d   = seg_q;
    en_d    = en_q;
    fd_d    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          // A suppressed digit keeps its slot time but stays dark.
          en_d    = sup[idx] ? 4'b0000 : (4'b0001 << idx);
          seg_d   = sup[idx] ? 7'h00 : dec_pat[idx];
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          en_d    = '0;
          seg_d   = '0;
          idx_d   = idx + 2'd1;
          fd_d    = boundary;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
      seg_q <= '0;
      en_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      seg_q <= seg_d;
      en_q  <= en_d;
      fd_q  <= fd_d;
    end
  end

  // A load landing on the boundary edge itself goes straight to the shadow
  // and discards any older pending value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (boundary) begin
      if (bus.load)           shadow <= bus.digits_in;
      else if (pending_valid) shadow <= pending;
      pending_valid <= 1'b0;
    end else if (bus.load) begin
      pending       <= bus.digits_in;
      pending_valid <= 1'b1;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DWELL=4, BLANK=2 (slot = 6 cycles,
// frame = 24 cycles). Positions p count clock edges from a frame start;
// slot s is lit on p = 6s+2 .. 6s+5 and frame_done is high only at p = 24.
module tb_seg7_scan_mux;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_mux_if bus();

  seg7_scan_mux #(.DWELL(4), .BLANK(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input int p, input logic [11:0] obs,
                     input logic [11:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  // Observed vector is {frame_done, digit_en, segments}.
  task automatic run_frame(input string tag, input logic [3:0][6:0] pat,
                           input logic [3:0] vis, input int last,
                           input int la1, input logic [15:0] lv1,
                           input int la2, input logic [15:0] lv2);
    int s;
    logic lit;
    logic [3:0] en;
    logic [6:0] seg;
    for (int p = 1; p <= last; p++) begin
      @(posedge clk); #1;
      bus.load = 1'b0;
      s   = p / 6;
      lit = (s < 4) && ((p % 6) >= 2);
      en  = '0;
      seg = '0;
      if (lit && vis[s]) begin
        en  = 4'b0001 << s;
        seg = pat[s];
      end
      chk(tag, p, {bus.frame_done, bus.digit_en, bus.segments},
          {(p == 24), en, seg});
      if (p == la1) begin bus.load = 1'b1; bus.digits_in = lv1; end
      if (p == la2) begin bus.load = 1'b1; bus.digits_in = lv2; end
    end
  endtask

  initial begin
    bus.digits_in = '0;
    bus.load      = 1'b0;
    bus.lzb       = 1'b0;
    #1;
    chk("reset_async", 0, {bus.frame_done, bus.digit_en, bus.segments}, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 0, {bus.frame_done, bus.digit_en, bus.segments}, 12'h000);
    reset_n = 1'b1;

    // Zeros frame; 0x1234 loaded mid-frame must wait for the boundary.
    run_frame("f1_zeros", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 24,
              10, 16'h1234, -1, 16'h0);
    // 1234 shows; pending 0x5555 is overridden by a boundary-cycle load.
    run_frame("f2_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 24,
              5, 16'h5555, 23, 16'h0987);
    run_frame("f3_0987", {7'h3F, 7'h6F, 7'h7F, 7'h07}, 4'b1111, 24,
              -1, 16'h0, -1, 16'h0);
    // Still 0987: the discarded pending value must not reappear.
    run_frame("f4_0987", {7'h3F, 7'h6F, 7'h7F, 7'h07}, 4'b1111, 24,
              10, 16'h0040, -1, 16'h0);
    bus.lzb = 1'b1;
    run_frame("f5_lzb_0040", {7'h3F, 7'h3F, 7'h66, 7'h3F}, 4'b0011, 24,
              10, 16'hFA09, -1, 16'h0);
    run_frame("f6_lzb_FA09", {7'h40, 7'h40, 7'h3F, 7'h6F}, 4'b1111, 24,
              -1, 16'h0, -1, 16'h0);
    bus.lzb = 1'b0;
    // Stop while digit 2 is lit, then reset between edges.
    run_frame("f7_pre_rst", {7'h40, 7'h40, 7'h3F, 7'h6F}, 4'b1111, 14,
              -1, 16'h0, -1, 16'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_show", 0, {bus.frame_done, bus.digit_en, bus.segments}, 12'h000);
    @(posedge clk); #1;
    chk("rst_mid_held", 0, {bus.frame_done, bus.digit_en, bus.segments}, 12'h000);
    reset_n = 1'b1;
    run_frame("f8_restart", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 24,
              -1, 16'h0, -1, 16'h0);
    bus.lzb = 1'b1;
    run_frame("f9_lzb_zero", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0001, 24,
              -1, 16'h0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
